// File: rtl/sram_page_reader_pkg.sv
// Shared definitions for the packet-SRAM page read path: geometry constants,
// the reader FSM states, the output FIFO entry and the per-page ECC step.
package sram_page_reader_pkg;

    localparam int PAGE_ADDR_WIDTH = 11;
    localparam int WORD_SEL_WIDTH  = 3;
    localparam int DATA_WIDTH      = 16;
    localparam int ECC_WIDTH       = 8;
    localparam int WORDS_PER_PAGE  = 8;
    localparam int PORT_WIDTH      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_RELEASE
    } rd_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [PORT_WIDTH-1:0] port;
    } fifo_entry_t;

    // Fold one data word into the running page code: bit i collects w[i]^w[i+8].
    // The write-side generator uses the same step so both ends agree.
    function automatic logic [ECC_WIDTH-1:0] page_ecc_step(
        input logic [ECC_WIDTH-1:0]  acc,
        input logic [DATA_WIDTH-1:0] word
    );
        return acc ^ word[ECC_WIDTH-1:0] ^ word[DATA_WIDTH-1:ECC_WIDTH];
    endfunction

endpackage

// File: rtl/sram_page_reader_fifo.sv
// Two-entry egress FIFO of {data, last, port}. The head entry drives the
// egress outputs directly from registers; count feeds the read-issue credit.
module sram_reader_fifo
    import sram_page_reader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic [PORT_WIDTH-1:0] push_port,
    input  logic                  head_ready,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [PORT_WIDTH-1:0] head_port,
    output logic                  pop,
    output logic [1:0]            count
);

    fifo_entry_t mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    fifo_entry_t head;

    // Head view and transfer qualification.
    always_comb begin
        head       = mem_q[rd_ptr_q];
        head_valid = (count_q != 2'd0);
        head_data  = head.data;
        head_last  = head.last;
        head_port  = head.port;
        pop        = head_valid && head_ready;
        count      = count_q;
    end

    // Storage, pointers and occupancy; the issue credit keeps push off a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{data: push_data, last: push_last, port: push_port};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/sram_page_reader.sv
// Page read engine: streams one SRAM page to egress, recomputes the page ECC
// over all eight words, compares it with the stored byte and releases the page.
module sram_page_reader
    import sram_page_reader_pkg::*;
#(
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      req_valid,
    output logic                                      req_ready,
    input  logic [PORT_WIDTH-1:0]                     req_port,
    input  logic [PAGE_ADDR_WIDTH-1:0]                req_addr,
    input  logic [WORD_SEL_WIDTH-1:0]                 req_len,
    output logic                                      sram_rd_en,
    output logic [PAGE_ADDR_WIDTH+WORD_SEL_WIDTH-1:0] sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]                     sram_dout,
    output logic                                      ecc_rd_en,
    output logic [PAGE_ADDR_WIDTH-1:0]                ecc_rd_addr,
    input  logic [ECC_WIDTH-1:0]                      ecc_dout,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [DATA_WIDTH-1:0]                     out_data,
    output logic                                      out_last,
    output logic [PORT_WIDTH-1:0]                     out_port,
    output logic                                      rd_op,
    output logic [PORT_WIDTH-1:0]                     rd_port,
    output logic [PAGE_ADDR_WIDTH-1:0]                rd_addr,
    output logic                                      ecc_err,
    output logic [ERR_CNT_WIDTH-1:0]                  err_cnt
);

    localparam logic [WORD_SEL_WIDTH-1:0] LAST_WORD = WORD_SEL_WIDTH'(WORDS_PER_PAGE - 1);

    rd_state_e                   state_q, state_d;
    logic                        run_q;
    logic [PORT_WIDTH-1:0]       port_q;
    logic [PAGE_ADDR_WIDTH-1:0]  addr_q;
    logic [WORD_SEL_WIDTH-1:0]   len_q;
    logic [WORD_SEL_WIDTH-1:0]   idx_q;
    logic                        issue_done_q;
    logic                        pend_q, pend_fwd_q, pend_last_q, pend_w7_q;
    logic                        ecc_pend_q;
    logic [ECC_WIDTH-1:0]        acc_q, ecc_hold_q;
    logic                        last_done_q;
    logic [ERR_CNT_WIDTH-1:0]    err_cnt_q;

    logic                        accept, issue, ecc_issue, fwd_word, credit_ok, mismatch;
    logic [2:0]                  occupancy;
    logic                        fifo_pop;
    logic [1:0]                  fifo_count;

    sram_reader_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (pend_q && pend_fwd_q),
        .push_data  (sram_dout),
        .push_last  (pend_last_q),
        .push_port  (port_q),
        .head_ready (out_ready),
        .head_valid (out_valid),
        .head_data  (out_data),
        .head_last  (out_last),
        .head_port  (out_port),
        .pop        (fifo_pop),
        .count      (fifo_count)
    );

    // Issue credit: buffered plus in-flight forwarded words, net of this cycle's pop, stays within 2.
    always_comb begin
        occupancy = {1'b0, fifo_count} + {2'b00, pend_q && pend_fwd_q};
        credit_ok = occupancy < (3'd2 + {2'b00, fifo_pop});
        fwd_word  = (idx_q <= len_q);
        mismatch  = (acc_q != ecc_hold_q);
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        issue     = 1'b0;
        ecc_issue = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && run_q) begin
                    accept  = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (!issue_done_q && (!fwd_word || credit_ok)) begin
                    issue     = 1'b1;
                    ecc_issue = (idx_q == '0);
                end
                if (pend_q && pend_w7_q) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (last_done_q || (fifo_pop && out_last)) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; release fields read zero outside the release cycle.
    always_comb begin
        req_ready    = (state_q == ST_IDLE) && run_q;
        sram_rd_en   = issue;
        sram_rd_addr = {addr_q, idx_q};
        ecc_rd_en    = ecc_issue;
        ecc_rd_addr  = addr_q;
        rd_op        = (state_q == ST_RELEASE);
        rd_port      = rd_op ? port_q : '0;
        rd_addr      = rd_op ? addr_q : '0;
        ecc_err      = rd_op && mismatch;
        err_cnt      = err_cnt_q;
    end

    // FSM state, request latch, word index and egress-last tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            port_q       <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            issue_done_q <= 1'b0;
            last_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (accept) begin
                port_q       <= req_port;
                addr_q       <= req_addr;
                len_q        <= req_len;
                idx_q        <= '0;
                issue_done_q <= 1'b0;
                last_done_q  <= 1'b0;
            end else begin
                if (issue) begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_WORD) begin
                        issue_done_q <= 1'b1;
                    end
                end
                if (fifo_pop && out_last) begin
                    last_done_q <= 1'b1;
                end
            end
        end
    end

    // In-flight read tags and ECC accumulation/capture as data returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_fwd_q  <= 1'b0;
            pend_last_q <= 1'b0;
            pend_w7_q   <= 1'b0;
            ecc_pend_q  <= 1'b0;
            acc_q       <= '0;
            ecc_hold_q  <= '0;
        end else begin
            pend_q      <= issue;
            pend_fwd_q  <= issue && fwd_word;
            pend_last_q <= (idx_q == len_q);
            pend_w7_q   <= (idx_q == LAST_WORD);
            ecc_pend_q  <= ecc_issue;
            if (ecc_pend_q) begin
                ecc_hold_q <= ecc_dout;
            end
            if (accept) begin
                acc_q <= '0;
            end else if (pend_q) begin
                acc_q <= page_ecc_step(acc_q, sram_dout);
            end
        end
    end

    // Saturating ECC mismatch counter, bumped in the release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (rd_op && mismatch && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_page_reader.sv
// Bench for sram_page_reader: SRAM/ECC memory models, egress monitor and a
// page-level reference (expected word list, ECC byte, error count).
`timescale 1ns/1ps
module tb_sram_page_reader;

    // Narrow error counter so saturation is reachable in a short run.
    localparam int ERR_W   = 3;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_port = '0;
    logic [10:0] req_addr = '0;
    logic [2:0]  req_len = '0;
    logic        sram_rd_en;
    logic [13:0] sram_rd_addr;
    logic [15:0] sram_dout = '0;
    logic        ecc_rd_en;
    logic [10:0] ecc_rd_addr;
    logic [7:0]  ecc_dout = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_last;
    logic [3:0]  out_port;
    logic        rd_op;
    logic [3:0]  rd_port;
    logic [10:0] rd_addr;
    logic        ecc_err;
    logic [ERR_W-1:0] err_cnt;

    always #5 clk = ~clk;

    sram_page_reader #(.ERR_CNT_WIDTH(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
        .req_addr(req_addr), .req_len(req_len),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_dout(sram_dout),
        .ecc_rd_en(ecc_rd_en), .ecc_rd_addr(ecc_rd_addr), .ecc_dout(ecc_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_port(out_port),
        .rd_op(rd_op), .rd_port(rd_port), .rd_addr(rd_addr),
        .ecc_err(ecc_err), .err_cnt(err_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Memories with one-cycle read latency.
    logic [15:0] sram_mem [0:16383];
    logic [7:0]  ecc_mem  [0:2047];
    always @(posedge clk) begin
        if (sram_rd_en) sram_dout <= sram_mem[sram_rd_addr];
        if (ecc_rd_en)  ecc_dout  <= ecc_mem[ecc_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Egress back-pressure patterns.
    int ready_mode = 0;
    int page_start = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = (((cyc - page_start) % 3) == 0);
            2:       out_ready = 1'($urandom_range(0, 1));
            3:       out_ready = ((cyc - page_start) > 25);
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor state, cleared per page.
    logic [15:0] got_data [$];
    logic        got_last [$];
    logic [3:0]  got_port [$];
    int          got_cyc  [$];
    int cur_len, issue_fwd, issue_total, first_issue_cyc, ecc_issue_cnt, ecc_issue_cyc;
    int rd_cnt, rd_cyc, orphan_err;
    logic [3:0]  rd_port_s;
    logic [10:0] rd_addr_s, ecc_addr_s;
    logic        ecc_err_s;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
                got_port.push_back(out_port);
                got_cyc.push_back(cyc);
            end
            if (sram_rd_en) begin
                issue_total++;
                if (first_issue_cyc < 0) first_issue_cyc = cyc;
                if (int'(sram_rd_addr[2:0]) <= cur_len) begin
                    issue_fwd++;
                    check_eq("outstanding_le2", 32'((issue_fwd - got_data.size()) <= 2), 1);
                end
            end
            if (ecc_rd_en) begin
                ecc_issue_cnt++;
                ecc_issue_cyc = cyc;
                ecc_addr_s = ecc_rd_addr;
            end
            if (rd_op) begin
                rd_cnt++;
                rd_cyc = cyc;
                rd_port_s = rd_port;
                rd_addr_s = rd_addr;
                ecc_err_s = ecc_err;
            end
            if (ecc_err && !rd_op) orphan_err++;
        end
    end

    logic [15:0] page_words [8];
    int exp_err = 0;

    // Page code straight from the definition: bit i is the XOR of w[i]^w[i+8] over all words.
    function automatic logic [7:0] model_ecc();
        logic [7:0] e;
        e = '0;
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 8; i++)
                e[i] = e[i] ^ page_words[k][i] ^ page_words[k][i+8];
        return e;
    endfunction

    task automatic clear_monitor(input int len);
        got_data.delete(); got_last.delete(); got_port.delete(); got_cyc.delete();
        cur_len = len; issue_fwd = 0; issue_total = 0; first_issue_cyc = -1;
        ecc_issue_cnt = 0; ecc_issue_cyc = -1; rd_cnt = 0; rd_cyc = -1; orphan_err = 0;
    endtask

    task automatic load_page(input logic [10:0] addr, input logic [7:0] flip);
        for (int k = 0; k < 8; k++) sram_mem[{addr, 3'(k)}] = page_words[k];
        ecc_mem[addr] = model_ecc() ^ flip;
    endtask

    task automatic send_req(input logic [3:0] port, input logic [10:0] addr, input int len, output int c0);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_port = port; req_addr = addr; req_len = 3'(len);
        c0 = -1; n = 0;
        while (c0 < 0 && n < 50) begin
            @(negedge clk);
            if (req_ready) c0 = cyc;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_port = '0; req_addr = '0; req_len = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_err = 0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_page(input logic [3:0] port, input logic [10:0] addr, input int len,
                            input logic [7:0] flip, input int mode, input bit timed);
        int c0, n;
        load_page(addr, flip);
        clear_monitor(len);
        ready_mode = mode;
        page_start = cyc;
        send_req(port, addr, len, c0);
        if (c0 < 0) begin
            check_eq("req_accept_timeout", 0, 1);
            return;
        end
        @(negedge clk);
        check_eq("busy_req_ready", req_ready, 0);
        n = 0;
        while (rd_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (rd_cnt == 0) begin
            check_eq("rd_op_timeout", 0, 1);
            do_reset();
            return;
        end
        if (flip != 0 && exp_err < ERR_MAX) exp_err++;
        @(negedge clk);
        check_eq("err_cnt", err_cnt, exp_err);
        check_eq("rd_op_once", rd_cnt, 1);
        check_eq("rd_port", rd_port_s, port);
        check_eq("rd_addr", rd_addr_s, addr);
        check_eq("ecc_err", ecc_err_s, flip != 0);
        check_eq("ecc_err_orphan", orphan_err, 0);
        check_eq("sram_reads", issue_total, 8);
        check_eq("ecc_reads", ecc_issue_cnt, 1);
        check_eq("ecc_rd_addr", ecc_addr_s, addr);
        check_eq("word_count", got_data.size(), len + 1);
        for (int k = 0; k <= len && k < got_data.size(); k++) begin
            check_eq($sformatf("w%0d_data", k), got_data[k], page_words[k]);
            check_eq($sformatf("w%0d_last", k), got_last[k], k == len);
            check_eq($sformatf("w%0d_port", k), got_port[k], port);
        end
        if (got_cyc.size() > 0)
            check_eq("rd_after_last_accept", got_cyc[got_cyc.size()-1] < rd_cyc, 1);
        if (timed) begin
            check_eq("lat_first_read", first_issue_cyc - c0, 1);
            check_eq("lat_ecc_read", ecc_issue_cyc - c0, 1);
            if (got_cyc.size() > 0) begin
                check_eq("lat_first_out", got_cyc[0] - c0, 3);
                check_eq("lat_last_out", got_cyc[got_cyc.size()-1] - c0, 3 + len);
            end
            check_eq("lat_rd_op", rd_cyc - c0, 11);
            check_eq("req_ready_again", req_ready, 1);
        end
    endtask

    task automatic seq_words();
        for (int k = 0; k < 8; k++) page_words[k] = {8'(k + 1), 8'(k + 1)};
    endtask

    task automatic rand_words();
        for (int k = 0; k < 8; k++) page_words[k] = 16'($urandom);
    endtask

    initial begin
        int c0, n, rd_before;
        logic [7:0] flip;
        int mode;

        clear_monitor(7);
        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_sram_rd_en", sram_rd_en, 0);
        check_eq("rst_rd_op", rd_op, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_sram_rd_addr", sram_rd_addr, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_req_ready", req_ready, 1);

        // Full page, clean ECC.
        seq_words();
        run_page(4'd3, 11'h005, 7, 8'h00, 0, 1'b1);
        // Same page, stored ECC bit 0 flipped.
        run_page(4'd3, 11'h005, 7, 8'h01, 0, 1'b1);
        // Single-word page at top address; unforwarded words carry data that must still be covered.
        rand_words();
        run_page(4'd15, 11'h7FF, 0, 8'h00, 0, 1'b1);
        // Back-pressure 1,0,0 pattern.
        rand_words();
        run_page(4'd6, 11'h123, 7, 8'h00, 1, 1'b0);
        // Sustained stall then release.
        rand_words();
        run_page(4'd9, 11'h2A4, 5, 8'h00, 3, 1'b0);

        // Randomized pages.
        for (int p = 0; p < 14; p++) begin
            rand_words();
            mode = $urandom_range(0, 3);
            flip = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
            run_page(4'($urandom), 11'($urandom), $urandom_range(0, 7), flip, mode, mode == 0);
        end

        // Drive the error counter into saturation, then one more mismatch.
        n = 0;
        while (exp_err < ERR_MAX && n < 20) begin
            rand_words();
            run_page(4'd1, 11'h040, $urandom_range(0, 7), 8'h80, 0, 1'b1);
            n++;
        end
        rand_words();
        run_page(4'd2, 11'h041, 3, 8'h10, 2, 1'b0);
        check_eq("err_cnt_saturated", err_cnt, ERR_MAX);

        // Reset while word 4 is being read.
        rand_words();
        load_page(11'h300, 8'h00);
        clear_monitor(7);
        ready_mode = 0;
        send_req(4'd5, 11'h300, 7, c0);
        check_eq("mid_rst_accept", c0 >= 0, 1);
        n = 0;
        while (!(sram_rd_en && sram_rd_addr[2:0] == 3'd4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_rst_reached_w4", sram_rd_en && sram_rd_addr[2:0] == 3'd4, 1);
        rd_before = rd_cnt;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_sram_rd_en", sram_rd_en, 0);
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_out_data", out_data, 0);
        check_eq("mid_rst_rd_op", rd_op, 0);
        check_eq("mid_rst_req_ready", req_ready, 0);
        check_eq("mid_rst_err_cnt", err_cnt, 0);
        exp_err = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_rst_req_ready_after", req_ready, 1);
        repeat (15) @(negedge clk);
        check_eq("mid_rst_no_rd_op", rd_cnt, rd_before);

        // Normal operation after the abort.
        rand_words();
        run_page(4'd5, 11'h300, 4, 8'h04, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
